// File: rtl/factor_pkg.sv
// Shared constants, game-state codes and helpers for the answer judge.
package factor_pkg;

  localparam int unsigned P1    = 2;
  localparam int unsigned P2    = 3;
  localparam int unsigned P3    = 5;
  localparam int unsigned MAX_Q = 999;
  localparam int unsigned ACC_W = 13;
  localparam int unsigned Q_W   = 10;
  localparam int unsigned EXP_W = 4;
  localparam int unsigned ST_W  = 4;

  // Game-state codes driven by the downstream controller
  localparam logic [ST_W-1:0] ST_INPUT = 4'b0100;
  localparam logic [ST_W-1:0] ST_DRAW  = 4'b0110;
  localparam logic [ST_W-1:0] ST_OUCH  = 4'b1000;
  localparam logic [ST_W-1:0] ST_GOOD  = 4'b1001;
  localparam logic [ST_W-1:0] ST_WIN   = 4'b1010;
  localparam logic [ST_W-1:0] ST_LOSE  = 4'b1011;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_MUL  = 2'd1,
    J_CMP  = 2'd2
  } judge_state_e;

  // Game states in which any judgement in flight is abandoned
  function automatic logic is_abort(input logic [ST_W-1:0] st);
    return (st == ST_DRAW) || (st == ST_OUCH) || (st == ST_GOOD) ||
           (st == ST_WIN)  || (st == ST_LOSE);
  endfunction

endpackage

// File: rtl/answer_judge_if.sv
// Handshake and data bundle between the input block, the judge and the game controller.
interface answer_judge_if;
  logic [3:0] STATE;
  logic       DEC;
  logic       QUE_OK;
  logic [3:0] COUNT1_IN;
  logic [3:0] COUNT2_IN;
  logic [3:0] COUNT3_IN;
  logic [3:0] Q_ONE;
  logic [3:0] Q_TEN;
  logic [3:0] Q_HUN;
  logic       BUSY;
  logic       DONE;
  logic       JUDGE_OK;
  logic       JUDGE_NG;

  modport master (
    output STATE, DEC, QUE_OK, COUNT1_IN, COUNT2_IN, COUNT3_IN, Q_ONE, Q_TEN, Q_HUN,
    input  BUSY, DONE, JUDGE_OK, JUDGE_NG
  );

  modport slave (
    input  STATE, DEC, QUE_OK, COUNT1_IN, COUNT2_IN, COUNT3_IN, Q_ONE, Q_TEN, Q_HUN,
    output BUSY, DONE, JUDGE_OK, JUDGE_NG
  );
endinterface

// File: rtl/bcd3_to_bin.sv
// Three BCD digits to binary; flags any digit above 9. Purely combinational.
module bcd3_to_bin
  import factor_pkg::*;
(
  input  logic [3:0]     hun_i,
  input  logic [3:0]     ten_i,
  input  logic [3:0]     one_i,
  output logic [Q_W-1:0] bin_o,
  output logic           bad_o
);

  // Weighted sum; value is meaningless when bad_o is set, so truncation is harmless
  assign bin_o = Q_W'(hun_i) * Q_W'(100) + Q_W'(ten_i) * Q_W'(10) + Q_W'(one_i);
  assign bad_o = (hun_i > 4'd9) || (ten_i > 4'd9) || (one_i > 4'd9);

endmodule

// File: rtl/answer_judge.sv
// Sequentially evaluates 2^a*3^b*5^c and judges it against the displayed question.
module answer_judge (
  input  logic           CLK,
  input  logic           RST,
  answer_judge_if.slave  bus
);
  import factor_pkg::*;

  judge_state_e     state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0] e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             ng_q, ng_d;

  logic [Q_W-1:0]   q_bin;
  logic             q_bad;
  logic [ACC_W-1:0] prod;
  logic             mul_en;
  logic             match;
  logic             start;

  bcd3_to_bin u_bcd (
    .hun_i (bus.Q_HUN),
    .ten_i (bus.Q_TEN),
    .one_i (bus.Q_ONE),
    .bin_o (q_bin),
    .bad_o (q_bad)
  );

  assign start = bus.DEC && bus.QUE_OK && (bus.STATE == ST_INPUT);
  assign match = !ovf_q && !bad_q && (acc_q == ACC_W'(q_q));

  // Next-state: abort first, then capture / one multiply per edge / compare
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    e3_d    = e3_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    ng_d    = ng_q;
    prod    = acc_q;
    mul_en  = 1'b0;

    if (is_abort(bus.STATE)) begin
      state_d = J_IDLE;
      busy_d  = 1'b0;
      ok_d    = 1'b0;
      ng_d    = 1'b0;
    end else begin
      case (state_q)
        J_IDLE: begin
          if (start) begin
            e1_d    = bus.COUNT1_IN;
            e2_d    = bus.COUNT2_IN;
            e3_d    = bus.COUNT3_IN;
            q_d     = q_bin;
            bad_d   = q_bad;
            ovf_d   = 1'b0;
            acc_d   = ACC_W'(1);
            ok_d    = 1'b0;
            ng_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = J_MUL;
          end
        end

        J_MUL: begin
          if (e1_q != '0) begin
            prod   = acc_q * ACC_W'(P1);
            e1_d   = e1_q - EXP_W'(1);
            mul_en = 1'b1;
          end else if (e2_q != '0) begin
            prod   = acc_q * ACC_W'(P2);
            e2_d   = e2_q - EXP_W'(1);
            mul_en = 1'b1;
          end else if (e3_q != '0) begin
            prod   = acc_q * ACC_W'(P3);
            e3_d   = e3_q - EXP_W'(1);
            mul_en = 1'b1;
          end

          if (!mul_en) begin
            state_d = J_CMP;
          end else begin
            acc_d = prod;
            // acc never exceeds MAX_Q before a multiply, so prod cannot wrap
            if (prod > ACC_W'(MAX_Q)) begin
              ovf_d   = 1'b1;
              state_d = J_CMP;
            end
          end
        end

        J_CMP: begin
          ok_d    = match;
          ng_d    = !match;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = J_IDLE;
        end

        default: state_d = J_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= J_IDLE;
      acc_q   <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      e3_q    <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      e3_q    <= e3_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      ng_q    <= ng_d;
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.JUDGE_OK = ok_q;
  assign bus.JUDGE_NG = ng_q;

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: vector table plus abort/reset/ignore sequences.
module tb_answer_judge;
  import factor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  answer_judge_if bus ();

  answer_judge dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] hun, ten, one;
    logic [3:0] e1, e2, e3;
    int         done_edge;
    logic       ok;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one judgement and check latency, verdict, pulse width and hold
  task automatic run_case(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input int exp_edge, input logic exp_ok, input string tag,
                          input int dec_again_edge);
    int got;
    @(negedge clk);
    bus.Q_HUN = h; bus.Q_TEN = t; bus.Q_ONE = o;
    bus.COUNT1_IN = a; bus.COUNT2_IN = b; bus.COUNT3_IN = c;
    bus.STATE = ST_INPUT; bus.QUE_OK = 1'b1; bus.DEC = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.DEC = 1'b0;
    chk({tag, " busy_after_start"}, int'(bus.BUSY), 1);
    got = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == dec_again_edge) bus.DEC = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.DEC = 1'b0;
      if (bus.DONE) begin
        got = i;
        break;
      end
    end
    chk({tag, " done_edge"}, got, exp_edge);
    chk({tag, " judge_ok"}, int'(bus.JUDGE_OK), int'(exp_ok));
    chk({tag, " judge_ng"}, int'(bus.JUDGE_NG), int'(!exp_ok));
    chk({tag, " busy_at_done"}, int'(bus.BUSY), 0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(bus.DONE), 0);
    repeat (5) @(negedge clk);
    chk({tag, " ok_held"}, int'(bus.JUDGE_OK), int'(exp_ok));
    chk({tag, " ng_held"}, int'(bus.JUDGE_NG), int'(!exp_ok));
  endtask

  initial begin
    int saw_done;

    vecs[0]  = '{4'd3, 4'd6, 4'd0, 4'd3, 4'd2, 4'd1,  8, 1'b1}; // 360 exact
    vecs[1]  = '{4'd3, 4'd6, 4'd0, 4'd2, 4'd2, 4'd1,  7, 1'b0}; // 180 vs 360
    vecs[2]  = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 11, 1'b0}; // overflow at 1536
    vecs[3]  = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0,  2, 1'b1}; // empty product = 1
    vecs[4]  = '{4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 4'd0,  2, 1'b0}; // bad ones digit
    vecs[5]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  2, 1'b0}; // 1 vs 0
    vecs[6]  = '{4'd5, 4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 11, 1'b1}; // 512
    vecs[7]  = '{4'd2, 4'd4, 4'd3, 4'd0, 4'd5, 4'd0,  7, 1'b1}; // 243
    vecs[8]  = '{4'd0, 4'd7, 4'd5, 4'd0, 4'd1, 4'd2,  5, 1'b1}; // 75
    vecs[9]  = '{4'd6, 4'd2, 4'd5, 4'd0, 4'd0, 4'd4,  6, 1'b1}; // 625
    vecs[10] = '{4'd6, 4'd2, 4'd5, 4'd0, 4'd0, 4'd5,  6, 1'b0}; // 3125 overflow on 5th
    vecs[11] = '{4'd9, 4'd6, 4'd0, 4'd6, 4'd1, 4'd1, 10, 1'b1}; // 960
    vecs[12] = '{4'd0, 4'hB, 4'd0, 4'd0, 4'd0, 4'd0,  2, 1'b0}; // bad tens digit
    vecs[13] = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 11, 1'b0}; // exponent 15, ovf at 1024

    bus.STATE = ST_INPUT; bus.DEC = 1'b0; bus.QUE_OK = 1'b0;
    bus.COUNT1_IN = '0; bus.COUNT2_IN = '0; bus.COUNT3_IN = '0;
    bus.Q_ONE = '0; bus.Q_TEN = '0; bus.Q_HUN = '0;
    #1;
    chk("reset busy", int'(bus.BUSY), 0);
    chk("reset done", int'(bus.DONE), 0);
    chk("reset ok", int'(bus.JUDGE_OK), 0);
    chk("reset ng", int'(bus.JUDGE_NG), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_case(vecs[k].hun, vecs[k].ten, vecs[k].one, vecs[k].e1, vecs[k].e2, vecs[k].e3,
               vecs[k].done_edge, vecs[k].ok, $sformatf("vec%0d", k), 0);
    end

    // DEC re-asserted while busy must not restart the computation
    run_case(4'd3, 4'd6, 4'd0, 4'd3, 4'd2, 4'd1, 8, 1'b1, "dec_while_busy", 3);

    // Abort while a verdict is held clears it
    @(negedge clk);
    bus.STATE = ST_GOOD;
    @(negedge clk);
    chk("abort_held ok", int'(bus.JUDGE_OK), 0);
    chk("abort_held ng", int'(bus.JUDGE_NG), 0);
    bus.STATE = ST_INPUT;

    // Abort mid-computation: 512 with exps 9,0,0, OUCH seen at edge 4
    @(negedge clk);
    bus.Q_HUN = 4'd5; bus.Q_TEN = 4'd1; bus.Q_ONE = 4'd2;
    bus.COUNT1_IN = 4'd9; bus.COUNT2_IN = 4'd0; bus.COUNT3_IN = 4'd0;
    bus.QUE_OK = 1'b1; bus.DEC = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.DEC = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", int'(bus.BUSY), 1);
    bus.STATE = ST_OUCH;
    @(negedge clk);
    chk("abort busy", int'(bus.BUSY), 0);
    chk("abort ok", int'(bus.JUDGE_OK), 0);
    chk("abort ng", int'(bus.JUDGE_NG), 0);
    bus.STATE = ST_INPUT;
    saw_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.DONE) saw_done = 1;
    end
    chk("abort no_done", saw_done, 0);
    chk("abort idle_busy", int'(bus.BUSY), 0);

    // DEC without QUE_OK, and DEC outside INPUT state, are ignored
    @(negedge clk);
    bus.QUE_OK = 1'b0; bus.DEC = 1'b1;
    @(negedge clk);
    bus.DEC = 1'b0;
    chk("no_que_ok busy", int'(bus.BUSY), 0);
    bus.QUE_OK = 1'b1; bus.STATE = 4'b0000; bus.DEC = 1'b1;
    @(negedge clk);
    bus.DEC = 1'b0; bus.STATE = ST_INPUT;
    chk("wrong_state busy", int'(bus.BUSY), 0);

    // Async reset mid-MUL clears BUSY without a clock edge
    bus.DEC = 1'b1;
    @(negedge clk);
    bus.DEC = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid busy_before", int'(bus.BUSY), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid busy", int'(bus.BUSY), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset clears a held verdict immediately
    run_case(4'd5, 4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 11, 1'b1, "pre_rst", 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_held ok", int'(bus.JUDGE_OK), 0);
    chk("rst_held ng", int'(bus.JUDGE_NG), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case(4'd3, 4'd6, 4'd0, 4'd3, 4'd2, 4'd1, 8, 1'b1, "post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
